// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one memory port, one transaction outstanding (MEM_ARBITER_FAIRNESS_EN adds anti-starvation).
// Latency: request issue is combinational from IDLE or in the cycle the prior response returns; responses are steered combinationally.
// Backpressure: ready to the selected requester follows mem_req_ready; requests wait while a transaction is outstanding.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ireq_valid,
    output logic        ireq_ready,
    input  logic [31:0] ireq_addr,
    output logic        iresp_valid,
    output logic [31:0] iresp_addr,
    output logic [31:0] iresp_inst,
    input  logic        dreq_valid,
    output logic        dreq_ready,
    input  logic [31:0] dreq_addr,
    input  logic        dreq_wen,
    input  logic [31:0] dreq_wdata,
    input  logic [3:0]  dreq_wmask,
    output logic        dresp_valid,
    output logic [31:0] dresp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_addr,
    input  logic [31:0] mem_resp_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t state_q, state_d;
    logic   can_issue, sel_i, issue;
    mreq_t  mreq;

`ifdef MEM_ARBITER_FAIRNESS_EN
    logic [3:0] starve_q;

    // Once data has won LIMIT times in a row, a waiting fetch takes the next slot.
    assign sel_i = ireq_valid && (!dreq_valid || (starve_q == LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!ireq_valid || (issue && sel_i)) begin
            starve_q <= '0;
        end else if (issue && (starve_q != LIMIT)) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    logic unused_limit;

    assign sel_i        = ireq_valid && !dreq_valid;
    assign unused_limit = ^LIMIT;
`endif

    // A response frees the port in the same cycle, so the next request can ride it.
    assign can_issue     = (state_q == IDLE) || mem_resp_valid;
    assign mem_req_valid = rst_n && can_issue && (ireq_valid || dreq_valid);
    assign ireq_ready    = rst_n && can_issue && mem_req_ready && sel_i;
    assign dreq_ready    = rst_n && can_issue && mem_req_ready && dreq_valid && !sel_i;
    assign issue         = mem_req_valid && mem_req_ready;

    always_comb begin
        mreq = '{addr: dreq_addr, wen: dreq_wen, wdata: dreq_wdata, wmask: dreq_wmask};
        if (sel_i) begin
            mreq = '{addr: ireq_addr, wen: 1'b0, wdata: 32'h0, wmask: 4'h0};
        end
    end

    assign mem_req_addr  = mreq.addr;
    assign mem_req_wen   = mreq.wen;
    assign mem_req_wdata = mreq.wdata;
    assign mem_req_wmask = mreq.wmask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        iresp_valid = 1'b0;
        iresp_addr  = 32'h0;
        iresp_inst  = 32'h0;
        dresp_valid = 1'b0;
        dresp_rdata = 32'h0;
        if (rst_n && mem_resp_valid && (state_q == WAIT_I)) begin
            iresp_valid = 1'b1;
            iresp_addr  = mem_resp_addr;
            iresp_inst  = mem_resp_rdata;
        end
        if (rst_n && mem_resp_valid && (state_q == WAIT_D)) begin
            dresp_valid = 1'b1;
            dresp_rdata = mem_resp_rdata;
        end
        if (issue) begin
            state_d = sel_i ? WAIT_I : WAIT_D;
        end else if (mem_resp_valid) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: IDLE-state vector table, then multi-cycle sequences
// (fetch, ordering, fairness, back-to-back, write, reset mid-transaction).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq_valid, ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_addr, iresp_inst;
    logic        dreq_valid, dreq_ready;
    logic [31:0] dreq_addr;
    logic        dreq_wen;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_wmask;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_addr, mem_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr),
        .iresp_valid(iresp_valid), .iresp_addr(iresp_addr), .iresp_inst(iresp_inst),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
        .dreq_wen(dreq_wen), .dreq_wdata(dreq_wdata), .dreq_wmask(dreq_wmask),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_addr(mem_resp_addr),
        .mem_resp_rdata(mem_resp_rdata)
    );

    typedef struct {
        logic iv; logic [31:0] ia;
        logic dv; logic [31:0] da; logic dwen; logic [31:0] dwd; logic [3:0] dwm;
        logic mrdy; logic rv; logic [31:0] ra; logic [31:0] rd;
        logic e_mv; logic e_ir; logic e_dr; logic [31:0] e_addr; logic e_wen;
        logic [31:0] e_wd; logic [3:0] e_wm; logic e_iv; logic e_dv;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireq_valid = 0; ireq_addr = 0;
        dreq_valid = 0; dreq_addr = 0; dreq_wen = 0; dreq_wdata = 0; dreq_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_addr = 0; mem_resp_rdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        cycle();
        rst_n = 1;
    endtask

    function automatic logic [191:0] pack_all();
        return {mem_req_valid, ireq_ready, dreq_ready, mem_req_addr, mem_req_wen,
                mem_req_wdata, mem_req_wmask, iresp_valid, iresp_addr, iresp_inst,
                dresp_valid, dresp_rdata};
    endfunction

    initial begin
        logic       prev_issue;
        logic [9:0] fetch_pat;
        logic [9:0] exp_pat;
        int         issues, pulses;

        //           iv ia       dv da       wen wdata         wm    rdy rv ra     rd       mv ir dr addr     wen wdata         wm    iv dv
        vecs[0] = '{0, 32'h0,   0, 32'h0,    0, 32'h0,        4'h0, 1, 0, 32'h0,  32'h0,   0, 0, 0, 32'h0,    0, 32'h0,        4'h0, 0, 0};
        vecs[1] = '{1, 32'h100, 0, 32'h0,    0, 32'h0,        4'h0, 1, 0, 32'h0,  32'h0,   1, 1, 0, 32'h100,  0, 32'h0,        4'h0, 0, 0};
        vecs[2] = '{0, 32'h0,   1, 32'h8000, 0, 32'h0,        4'h0, 1, 0, 32'h0,  32'h0,   1, 0, 1, 32'h8000, 0, 32'h0,        4'h0, 0, 0};
        vecs[3] = '{1, 32'h200, 1, 32'h8000, 0, 32'h0,        4'h0, 1, 0, 32'h0,  32'h0,   1, 0, 1, 32'h8000, 0, 32'h0,        4'h0, 0, 0};
        vecs[4] = '{1, 32'h200, 1, 32'h8000, 0, 32'h0,        4'h0, 0, 0, 32'h0,  32'h0,   1, 0, 0, 32'h8000, 0, 32'h0,        4'h0, 0, 0};
        vecs[5] = '{0, 32'h0,   1, 32'h8004, 1, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,  32'h0,   1, 0, 1, 32'h8004, 1, 32'hDEADBEEF, 4'hF, 0, 0};
        vecs[6] = '{1, 32'h104, 0, 32'h0,    0, 32'h0,        4'h0, 0, 0, 32'h0,  32'h0,   1, 0, 0, 32'h104,  0, 32'h0,        4'h0, 0, 0};
        vecs[7] = '{1, 32'h108, 0, 32'h8008, 1, 32'h0,        4'hA, 1, 0, 32'h0,  32'h0,   1, 1, 0, 32'h108,  0, 32'h0,        4'h0, 0, 0};
        vecs[8] = '{0, 32'h0,   0, 32'h0,    0, 32'h0,        4'h0, 1, 1, 32'h44, 32'h55,  0, 0, 0, 32'h0,    0, 32'h0,        4'h0, 0, 0};
        vecs[9] = '{1, 32'h10C, 0, 32'h0,    0, 32'h0,        4'h0, 1, 1, 32'h44, 32'h55,  1, 1, 0, 32'h10C,  0, 32'h0,        4'h0, 0, 0};

        rst_n = 0;
        clear_inputs();
        cycle();
        cycle();

        // Each vector is applied to a freshly reset (IDLE) arbiter.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            ireq_valid = vecs[i].iv; ireq_addr = vecs[i].ia;
            dreq_valid = vecs[i].dv; dreq_addr = vecs[i].da; dreq_wen = vecs[i].dwen;
            dreq_wdata = vecs[i].dwd; dreq_wmask = vecs[i].dwm;
            mem_req_ready = vecs[i].mrdy; mem_resp_valid = vecs[i].rv;
            mem_resp_addr = vecs[i].ra; mem_resp_rdata = vecs[i].rd;
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_all(),
                  {vecs[i].e_mv, vecs[i].e_ir, vecs[i].e_dr, vecs[i].e_addr, vecs[i].e_wen,
                   vecs[i].e_wd, vecs[i].e_wm, vecs[i].e_iv, 64'h0, vecs[i].e_dv, 32'h0});
        end

        // Fetch only, response two cycles after issue.
        do_reset();
        ireq_valid = 1; ireq_addr = 32'h100; mem_req_ready = 1;
        @(negedge clk);
        check("fetch_issue", {mem_req_valid, ireq_ready, mem_req_addr}, {1'b1, 1'b1, 32'h100});
        cycle();
        ireq_addr = 32'h104;
        @(negedge clk);
        check("fetch_wait_blocks", {mem_req_valid, ireq_ready}, 2'b00);
        cycle();
        ireq_valid = 0; mem_resp_valid = 1; mem_resp_addr = 32'h100; mem_resp_rdata = 32'h13;
        @(negedge clk);
        check("fetch_resp", {iresp_valid, iresp_addr, iresp_inst, dresp_valid},
              {1'b1, 32'h100, 32'h13, 1'b0});
        cycle();
        mem_resp_valid = 0;
        @(negedge clk);
        check("fetch_resp_gone", {iresp_valid, iresp_addr, iresp_inst}, 65'h0);

        // Simultaneous requests: data first, fetch issues in the data-response cycle.
        do_reset();
        ireq_valid = 1; ireq_addr = 32'h200; dreq_valid = 1; dreq_addr = 32'h8000; mem_req_ready = 1;
        @(negedge clk);
        check("both_data_first", {dreq_ready, ireq_ready, mem_req_addr}, {1'b1, 1'b0, 32'h8000});
        cycle();
        dreq_valid = 0;
        @(negedge clk);
        check("both_wait_d", mem_req_valid, 1'b0);
        cycle();
        mem_resp_valid = 1; mem_resp_addr = 32'h8000; mem_resp_rdata = 32'hCAFE0001;
        @(negedge clk);
        check("both_dresp_and_fetch",
              {dresp_valid, dresp_rdata, iresp_valid, mem_req_valid, ireq_ready, mem_req_addr},
              {1'b1, 32'hCAFE0001, 1'b0, 1'b1, 1'b1, 32'h200});
        cycle();
        ireq_valid = 0; mem_resp_addr = 32'h200; mem_resp_rdata = 32'h13;
        @(negedge clk);
        check("both_iresp", {iresp_valid, iresp_addr, iresp_inst, dresp_valid},
              {1'b1, 32'h200, 32'h13, 1'b0});

        // Fairness with a one-cycle-latency memory and both requesters always valid.
        do_reset();
        ireq_valid = 1; ireq_addr = 32'h300; dreq_valid = 1; dreq_addr = 32'h9000; mem_req_ready = 1;
        prev_issue = 0; fetch_pat = '0; issues = 0;
        for (int c = 0; c < 10; c++) begin
            mem_resp_valid = prev_issue; mem_resp_rdata = 32'(c);
            @(negedge clk);
            prev_issue = mem_req_valid && mem_req_ready;
            if (prev_issue) issues++;
            fetch_pat[c] = ireq_ready;
            cycle();
        end
`ifdef MEM_ARBITER_FAIRNESS_EN
        exp_pat = 10'b10_0001_0000;
`else
        exp_pat = 10'b00_0000_0000;
`endif
        check("fair_pattern", fetch_pat, exp_pat);
        check("fair_issue_count", issues, 10);

        // Back-to-back fetches with a one-cycle-latency memory.
        do_reset();
        ireq_valid = 1; ireq_addr = 32'h400; mem_req_ready = 1;
        prev_issue = 0; issues = 0; pulses = 0;
        for (int c = 0; c < 6; c++) begin
            mem_resp_valid = prev_issue; mem_resp_addr = 32'h400;
            @(negedge clk);
            prev_issue = mem_req_valid && mem_req_ready && ireq_ready;
            if (prev_issue) issues++;
            if (iresp_valid) pulses++;
            cycle();
        end
        check("b2b_issues", issues, 6);
        check("b2b_iresp", pulses, 5);

        // Write transfer and its single acknowledgement.
        do_reset();
        dreq_valid = 1; dreq_wen = 1; dreq_addr = 32'h8004; dreq_wdata = 32'hDEADBEEF;
        dreq_wmask = 4'hF; mem_req_ready = 1;
        @(negedge clk);
        check("write_port",
              {mem_req_valid, dreq_ready, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask},
              {1'b1, 1'b1, 32'h8004, 1'b1, 32'hDEADBEEF, 4'hF});
        cycle();
        dreq_valid = 0; pulses = 0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = (k == 1);
            @(negedge clk);
            if (dresp_valid) pulses++;
            cycle();
        end
        check("write_ack_once", pulses, 1);

        // Reset while a data read is outstanding, then a stray response.
        do_reset();
        dreq_valid = 1; dreq_addr = 32'h8010; mem_req_ready = 1;
        cycle();
        rst_n = 0; ireq_valid = 1; mem_resp_valid = 1;
        @(negedge clk);
        check("in_reset_quiet", {mem_req_valid, ireq_ready, dreq_ready, iresp_valid, dresp_valid}, 5'b0);
        cycle();
        rst_n = 1; ireq_valid = 0; dreq_valid = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h77;
        @(negedge clk);
        check("stray_resp_ignored", {dresp_valid, iresp_valid, dresp_rdata}, 34'h0);
        cycle();
        mem_resp_valid = 0; ireq_valid = 1; ireq_addr = 32'h500;
        @(negedge clk);
        check("stays_idle", {mem_req_valid, ireq_ready, mem_req_addr}, {1'b1, 1'b1, 32'h500});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
